// File: rtl/vec_alu_pkg.sv
// Shared definitions for the SIMD vector ALU: funct6 codes, SEW encodings,
// FSM states, the legality check and the per-element operation kernel.
package vec_alu_pkg;

  localparam logic [5:0] OP_VADD  = 6'b000000;
  localparam logic [5:0] OP_VSUB  = 6'b000010;
  localparam logic [5:0] OP_VMINU = 6'b000100;
  localparam logic [5:0] OP_VMIN  = 6'b000101;
  localparam logic [5:0] OP_VMAXU = 6'b000110;
  localparam logic [5:0] OP_VMAX  = 6'b000111;
  localparam logic [5:0] OP_VAND  = 6'b001001;
  localparam logic [5:0] OP_VOR   = 6'b001010;
  localparam logic [5:0] OP_VXOR  = 6'b001011;

  localparam logic [2:0] SEW8  = 3'b000;
  localparam logic [2:0] SEW16 = 3'b001;
  localparam logic [2:0] SEW32 = 3'b010;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  function automatic logic is_legal(input logic [5:0] opcode, input logic [2:0] vsew);
    logic op_ok;
    case (opcode)
      OP_VADD, OP_VSUB, OP_VMINU, OP_VMIN, OP_VMAXU,
      OP_VMAX, OP_VAND, OP_VOR, OP_VXOR: op_ok = 1'b1;
      default:                           op_ok = 1'b0;
    endcase
    return op_ok && (vsew == SEW8 || vsew == SEW16 || vsew == SEW32);
  endfunction

  // Operands arrive MSB-aligned (element in the top SEW bits, zeros below),
  // so one 32-bit kernel serves every SEW: wrap-around and signed compare
  // both happen at the element's own MSB. x is vs2, y is vs1.
  function automatic logic [31:0] elem_op(input logic [5:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    logic [31:0] r;
    case (op)
      OP_VADD:  r = x + y;
      OP_VSUB:  r = x - y;
      OP_VMINU: r = (x < y) ? x : y;
      OP_VMIN:  r = ($signed(x) < $signed(y)) ? x : y;
      OP_VMAXU: r = (x > y) ? x : y;
      OP_VMAX:  r = ($signed(x) > $signed(y)) ? x : y;
      OP_VAND:  r = x & y;
      OP_VOR:   r = x | y;
      OP_VXOR:  r = x ^ y;
      default:  r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vec_alu_simd_lane.sv
// One SIMD lane: LANE_W bits split into LANE_W/SEW independent elements.
// Elements whose enable bit is clear pass the old vd value through.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic [LANE_W-1:0]   a_i,
  input  logic [LANE_W-1:0]   b_i,
  input  logic [LANE_W-1:0]   old_i,
  input  logic [2:0]          vsew_i,
  input  logic [5:0]          opcode_i,
  input  logic [LANE_W/8-1:0] en_i,
  output logic [LANE_W-1:0]   res_o
);

  logic [31:0] r;

  // Segmented per-element compute; enable bit e refers to element e of this lane.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit -- no latch is inferred.
    res_o = old_i;
    r     = '0;
    case (vsew_i)
      SEW8: begin
        for (int e = 0; e < LANE_W / 8; e++) begin
          if (en_i[e]) begin
            r = elem_op(opcode_i, {a_i[e*8 +: 8], 24'd0}, {b_i[e*8 +: 8], 24'd0});
            res_o[e*8 +: 8] = r[31:24];
          end
        end
      end
      SEW16: begin
        for (int e = 0; e < LANE_W / 16; e++) begin
          if (en_i[e]) begin
            r = elem_op(opcode_i, {a_i[e*16 +: 16], 16'd0}, {b_i[e*16 +: 16], 16'd0});
            res_o[e*16 +: 16] = r[31:16];
          end
        end
      end
      SEW32: begin
        for (int e = 0; e < LANE_W / 32; e++) begin
          if (en_i[e]) begin
            r = elem_op(opcode_i, a_i[e*32 +: 32], b_i[e*32 +: 32]);
            res_o[e*32 +: 32] = r;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vec_alu_simd.sv
// Multi-cycle SIMD integer ALU: latches one vector group on start, computes
// one CW-bit chunk per RUN cycle, then reports done (and illegal) for a cycle.
module vec_alu_simd
  import vec_alu_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1,
  parameter int LANE_W   = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [5:0]      opcode,
  input  logic [2:0]      vsew,
  input  logic [7:0]      vl,
  input  logic            vm,
  input  logic [VLEN-1:0] v0,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vd_old,
  output logic [VLEN-1:0] vd,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  localparam int NLANES = 1 << NB_LANES;
  localparam int CW     = NLANES * LANE_W;
  localparam int NCHUNK = VLEN / CW;
  localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int EPL    = LANE_W / 8;

  state_e          state_q, state_d;
  logic [CHW-1:0]  chunk_q, chunk_d;
  logic            busy_q, busy_d, done_q, done_d, illegal_q, illegal_d, ill_q;
  logic            accept;
  logic [5:0]      op_q;
  logic [2:0]      sew_q;
  logic [7:0]      vl_q;
  logic            vm_q;
  logic [VLEN-1:0] v0_q, vs1_q, vs2_q, vd_q;

  logic [CW-1:0]   a_c, b_c, old_c, res_c;
  logic [NLANES-1:0][EPL-1:0] en;

  // FSM next state; done/illegal are registered so they form a clean one-cycle pulse.
  always_comb begin
    state_d   = state_q;
    chunk_d   = chunk_q;
    busy_d    = done_q ? 1'b0 : busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        // busy_q still covers the done cycle, so a start there is ignored.
        if (start && !busy_q) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          chunk_d = '0;
          state_d = is_legal(opcode, vsew) ? RUN : FIN;
        end
      end
      RUN: begin
        chunk_d = chunk_q + 1'b1;
        if (chunk_q == CHW'(NCHUNK - 1)) begin
          chunk_d = '0;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        illegal_d = ill_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and vd; a synchronous reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      chunk_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ill_q     <= 1'b0;
      vd_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      chunk_q   <= chunk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (accept) begin
        ill_q <= !is_legal(opcode, vsew);
        vd_q  <= vd_old;
      end else if (state_q == RUN) begin
        vd_q[int'(chunk_q)*CW +: CW] <= res_c;
      end
    end
  end

  // Operand latches captured on acceptance.
  // NOTE: datapath latches are not reset; control never reads them before a start loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= opcode;
      sew_q <= vsew;
      vl_q  <= vl;
      vm_q  <= vm;
      v0_q  <= v0;
      vs1_q <= vs1;
      vs2_q <= vs2;
    end
  end

  // Current chunk slices and per-element enables (tail clamp to VLMAX plus v0 mask).
  always_comb begin
    int sew_bits, vlmax, vlc, base, idx;
    a_c      = vs2_q[int'(chunk_q)*CW +: CW];
    b_c      = vs1_q[int'(chunk_q)*CW +: CW];
    old_c    = vd_q[int'(chunk_q)*CW +: CW];
    en       = '0;
    case (sew_q)
      SEW16:   sew_bits = 16;
      SEW32:   sew_bits = 32;
      default: sew_bits = 8;
    endcase
    vlmax = VLEN / sew_bits;
    vlc   = (int'(vl_q) < vlmax) ? int'(vl_q) : vlmax;
    for (int l = 0; l < NLANES; l++) begin
      base = (int'(chunk_q) * CW + l * LANE_W) / sew_bits;
      for (int k = 0; k < EPL; k++) begin
        idx = base + k;
        if (k < LANE_W / sew_bits && idx < vlc) begin
          en[l][k] = vm_q || v0_q[idx];
        end
      end
    end
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    vec_alu_lane #(.LANE_W(LANE_W)) u_lane (
      .a_i      (a_c[l*LANE_W +: LANE_W]),
      .b_i      (b_c[l*LANE_W +: LANE_W]),
      .old_i    (old_c[l*LANE_W +: LANE_W]),
      .vsew_i   (sew_q),
      .opcode_i (op_q),
      .en_i     (en[l]),
      .res_o    (res_c[l*LANE_W +: LANE_W])
    );
  end

  assign vd      = vd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_vec_alu_simd.sv
// Scoreboard bench for vec_alu_simd (VLEN=128, 2 lanes x 32 bits, 2 chunks).
// Stimulus pushes the expected vd/illegal/latency; the monitor pops on done.
module tb_vec_alu_simd;
  import vec_alu_pkg::*;

  logic         clk = 1'b0;
  logic         resetn, start, vm;
  logic [5:0]   opcode;
  logic [2:0]   vsew;
  logic [7:0]   vl;
  logic [127:0] v0, vs1, vs2, vd_old, vd;
  logic         busy, done, illegal;

  typedef struct {
    logic [127:0] vd;
    logic         ill;
    int           lat;
    int           issue;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   op_id    = 0;

  vec_alu_simd #(.VLEN(128), .NB_LANES(1), .LANE_W(32)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .opcode  (opcode),
    .vsew    (vsew),
    .vl      (vl),
    .vm      (vm),
    .v0      (v0),
    .vs1     (vs1),
    .vs2     (vs2),
    .vd_old  (vd_old),
    .vd      (vd),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (illegal && !done) begin
      n_checks++;
      $display("FAIL illegal_without_done at cycle %0d", cyc);
    end
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending op", cyc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("vd_op%0d", e.id), vd, e.vd);
        check($sformatf("illegal_op%0d", e.id), {127'd0, illegal}, {127'd0, e.ill});
        check($sformatf("latency_op%0d", e.id), 128'(cyc - e.issue), 128'(e.lat));
      end
    end
  end

  // Issue one request; latency is counted in edges after the edge that samples start
  // (3 for a legal op: two RUN chunks then FIN; 1 for an illegal op that goes straight to FIN).
  // poke re-asserts start with different operands while the op is busy.
  task automatic run_op(input logic [5:0] op, input logic [2:0] sew, input logic [7:0] len,
                        input logic m, input logic [127:0] mask, input logic [127:0] a1,
                        input logic [127:0] a2, input logic [127:0] old,
                        input logic [127:0] exp_vd, input logic exp_ill, input logic poke);
    exp_t e;
    int   d0, i;
    @(negedge clk);
    opcode = op; vsew = sew; vl = len; vm = m; v0 = mask;
    vs1 = a1; vs2 = a2; vd_old = old; start = 1'b1;
    op_id++;
    e.vd = exp_vd; e.ill = exp_ill; e.lat = exp_ill ? 1 : 3; e.issue = cyc + 1; e.id = op_id;
    exp_q.push_back(e);
    d0 = n_done;
    @(negedge clk);
    start = poke;
    opcode = OP_VXOR; vsew = SEW8; vl = 8'd16; vm = 1'b1;
    v0 = '0; vs1 = ~a1; vs2 = ~a2; vd_old = ~old;
    check($sformatf("busy_after_accept_op%0d", op_id), {127'd0, busy}, 128'd1);
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (n_done == d0 && i < 20) begin
      @(posedge clk);
      i++;
    end
    if (n_done == d0) begin
      n_checks++;
      $display("FAIL timeout_op%0d: got no done in 20 cycles required done", op_id);
    end
    @(negedge clk);
    check($sformatf("busy_cleared_op%0d", op_id), {127'd0, busy}, 128'd0);
    check($sformatf("done_single_op%0d", op_id), {127'd0, done}, 128'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; opcode = '0; vsew = '0; vl = '0; vm = 1'b1;
    v0 = '0; vs1 = '0; vs2 = '0; vd_old = '0;
    repeat (3) @(negedge clk);
    check("reset_vd", vd, 128'd0);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    check("reset_illegal", {127'd0, illegal}, 128'd0);
    resetn = 1'b1;

    // vadd SEW8: 0xFF + 0x02 = 0x01 per byte, no carry between bytes; start poked while busy.
    run_op(OP_VADD, SEW8, 8'd16, 1'b1, '0, {16{8'h02}}, {16{8'hFF}}, '0,
           {16{8'h01}}, 1'b0, 1'b1);
    // vmin signed vs vminu, SEW16.
    run_op(OP_VMIN, SEW16, 8'd8, 1'b1, '0, {8{16'h0001}}, {8{16'h8000}}, '0,
           {8{16'h8000}}, 1'b0, 1'b0);
    run_op(OP_VMINU, SEW16, 8'd8, 1'b1, '0, {8{16'h0001}}, {8{16'h8000}}, '0,
           {8{16'h0001}}, 1'b0, 1'b0);
    // vand SEW32, vl=2: words 2..3 keep vd_old; vl=200 clamps to all 4 words.
    run_op(OP_VAND, SEW32, 8'd2, 1'b1, '0,
           128'hFFFF_0000_F0F0_0F0F_0F0F_F0F0_00FF_FF00,
           128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, {16{8'hA5}},
           {64'hA5A5_A5A5_A5A5_A5A5, 64'h0E0C_B090_0054_3200}, 1'b0, 1'b0);
    run_op(OP_VAND, SEW32, 8'd200, 1'b1, '0,
           128'hFFFF_0000_F0F0_0F0F_0F0F_F0F0_00FF_FF00,
           128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, {16{8'hA5}},
           128'h0123_0000_80A0_0D0F_0E0C_B090_0054_3200, 1'b0, 1'b0);
    // vxor SEW8 masked by v0 = ...5555: even bytes written, odd bytes keep 0.
    run_op(OP_VXOR, SEW8, 8'd16, 1'b0, {{112{1'b1}}, 16'h5555}, {16{8'h0F}}, {16{8'h3C}}, '0,
           {8{16'h0033}}, 1'b0, 1'b0);
    // vsub SEW16, vl=3: 0 - 1 = 0xFFFF in elements 0..2.
    run_op(OP_VSUB, SEW16, 8'd3, 1'b1, '0, {8{16'h0001}}, '0, {8{16'h1234}},
           {{5{16'h1234}}, {3{16'hFFFF}}}, 1'b0, 1'b0);
    // vmax signed vs vmaxu, SEW32.
    run_op(OP_VMAX, SEW32, 8'd4, 1'b1, '0, {4{32'h7FFF_FFFF}}, {4{32'h8000_0000}}, '0,
           {4{32'h7FFF_FFFF}}, 1'b0, 1'b0);
    run_op(OP_VMAXU, SEW32, 8'd4, 1'b1, '0, {4{32'h7FFF_FFFF}}, {4{32'h8000_0000}}, '0,
           {4{32'h8000_0000}}, 1'b0, 1'b0);
    // vmax SEW8 masked to the upper 8 bytes.
    run_op(OP_VMAX, SEW8, 8'd16, 1'b0, {112'd0, 16'hFF00}, {16{8'h7F}}, {16{8'h80}}, {16{8'h11}},
           {{8{8'h7F}}, {8{8'h11}}}, 1'b0, 1'b0);
    // vor with vl=0 leaves vd_old.
    run_op(OP_VOR, SEW16, 8'd0, 1'b1, '0, {16{8'hF0}}, {16{8'h0F}},
           128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D,
           128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D, 1'b0, 1'b0);
    // Illegal opcode and illegal vsew; start poked during FIN and the done cycle.
    run_op(6'b111111, SEW8, 8'd16, 1'b1, '0, {16{8'h01}}, {16{8'h02}},
           128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
           128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1'b1, 1'b1);
    run_op(OP_VADD, 3'b011, 8'd16, 1'b1, '0, {16{8'h01}}, {16{8'h02}}, {8{16'h5A5A}},
           {8{16'h5A5A}}, 1'b1, 1'b0);

    // Reset during RUN chunk 1 aborts with no done pulse.
    @(negedge clk);
    opcode = OP_VADD; vsew = SEW8; vl = 8'd16; vm = 1'b1;
    vs1 = {16{8'h01}}; vs2 = {16{8'h01}}; vd_old = {16{8'h77}}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_vd", vd, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_done", {127'd0, done}, 128'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    run_op(OP_VADD, SEW8, 8'd16, 1'b1, '0, {16{8'h01}}, {16{8'h01}}, {16{8'h77}},
           {16{8'h02}}, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
